keypad_scanner_param: RTL
=========================

Name: keypad_scanner_param

Overview:
- Parametrised matrix-keypad scanner for ROWS x COLS keypads.
- Sequentially drives one column low and samples the row lines through a 2-flop synchronizer.
- Debounces single-key presses over whole scan frames, rejects multi-key presses, and presents a {row,col} key code with a KeyRdy/KeyRd handshake.
- Settle timing is generated internally (no external LFSR). A press is reported only after the previous key has been released and the release has been debounced.

Parameters:
- ROWS, 4, number of row inputs (2..8).
- COLS, 4, number of column outputs (2..8).
- SETTLE_CYCLES, 16, clocks each column is held before the rows are sampled (>=3).
- DEBOUNCE_FRAMES, 4, consecutive identical frames needed to accept a press or a release (1..15).
- REPEAT_FRAMES, 32, frames between auto-repeat reports (only used with KEYPAD_REPEAT_EN).

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- RowIn  in  ROWS  asynchronous row lines, externally pulled up; low = key closed on the active column.
- ColOut  out  COLS  open-drain columns: the active column drives 0, all others are high-Z.
- KeyRdy  out  1  high while KeyCode holds an unread key.
- KeyRd  in  1  consumer acknowledge; sampled only while KeyRdy=1.
- KeyCode  out  $clog2(ROWS)+$clog2(COLS)  {row_idx, col_idx} of the accepted key.
- KeyDown  out  1  level: a debounced single key is currently held.
- MultiKey  out  1  one-cycle pulse when a frame contains more than one closed key.

Behaviour:
- Reset (sync, active-high): all ColOut high-Z; KeyRdy=0, KeyCode=0, KeyDown=0, MultiKey=0; internal counters and candidate cleared; FSM=SCAN with col_idx=0. Column 0 drives low on the first cycle after Reset falls. Reset asserted mid-frame or mid-handshake aborts immediately; no partial report is made.
- Column timing: each column is held for SETTLE_CYCLES clocks. On the last clock of the hold, the synchronized RowIn is written into the frame snapshot slice for that column. Column index then increments and wraps from COLS-1 to 0. One frame = COLS*SETTLE_CYCLES clocks.
- Scanning runs continuously in every state, including during the handshake, so release can still be detected.
- Frame evaluation (one cycle after column COLS-1 is sampled):
  - count = number of zero bits in the snapshot.
  - count==0: empty frame.
  - count==1: single frame; candidate code = {row of zero bit, column}.
  - count>=2: multi frame; MultiKey pulses for 1 cycle and the frame is treated as empty for debounce.
- FSM states IDLE, PRESS_DB, WAIT_READ, RELEASE_DB.
  - IDLE: a single frame loads the candidate, sets stable_cnt=1, and goes to PRESS_DB. If DEBOUNCE_FRAMES==1, it goes straight to WAIT_READ.
  - PRESS_DB:
    - Same candidate: stable_cnt++.
    - stable_cnt reaches DEBOUNCE_FRAMES: KeyCode<=candidate, KeyRdy<=1, KeyDown<=1, go to WAIT_READ.
    - Different single key: reload candidate, stable_cnt=1.
    - Empty or multi frame: go to IDLE.
  - WAIT_READ:
    - KeyRdy held and KeyCode frozen.
    - KeyRd=1 while KeyRdy=1: KeyRdy<=0 next cycle, go to RELEASE_DB.
    - KeyRd while KeyRdy=0 is ignored.
    - KeyRd arriving in the same cycle KeyRdy first rises is not acknowledged; it must still be high on a later cycle.
  - RELEASE_DB:
    - Counts consecutive empty frames. At DEBOUNCE_FRAMES: KeyDown<=0, go to IDLE.
    - Any non-empty frame restarts the count.
    - A different key pressed before release is never reported.
- KeyDown also falls if the key releases while still in WAIT_READ. Release is tracked there with the same empty-frame count. KeyRdy stays high until it is read.
- stable_cnt saturates and never wraps.
- The row decode is one-hot on the zero bit only; a snapshot with count==1 is the only source of KeyCode.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in RELEASE_DB, while the same key (same single candidate) stays held, a repeat counter counts frames. On reaching REPEAT_FRAMES it re-asserts KeyRdy with an unchanged KeyCode, goes to WAIT_READ, and clears the counter. Any other frame type clears the repeat counter.
- Undefined: no repeat counter is built; a held key is reported exactly once.

Test Plan (ROWS=4, COLS=4, SETTLE_CYCLES=4, DEBOUNCE_FRAMES=3, frame=16 clocks):
- Reset, then idle rows 4'hF -> ColOut sequence 1110,1101,1011,0111 in z/0 encoding, 4 clocks each; KeyRdy stays 0.
- Hold row 2 low only while column 1 is driven, for 5 frames -> KeyRdy=1 within 3 frames + 1 cycle; KeyCode=4'b1001; KeyDown=1.
- Press a key, keep KeyRd low -> KeyRdy stays 1 and KeyCode is stable; pulse KeyRd -> KeyRdy=0 next cycle; release -> KeyDown=0 after 3 empty frames.
- Press (r0,c0) and (r3,c2) together -> MultiKey pulses once per frame; KeyRdy never rises.
- Bounce: key closed on alternate frames for 10 frames -> no report; assert Reset mid-PRESS_DB -> all outputs return to reset values next cycle.
- KEYPAD_REPEAT_EN with REPEAT_FRAMES=8: hold (r1,c3) after read -> KeyRdy re-asserts every 8 frames with KeyCode=4'b0111; undefined -> exactly one report.

Source files
------------

// File: rtl/keypad_scanner_param.sv
// rtl/keypad_scanner_param.sv - matrix keypad scanner with frame debounce and KeyRdy/KeyRd handshake
// Optional auto-repeat of a held key is built when KEYPAD_REPEAT_EN is defined.
module keypad_scanner_param #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 32
) (
  input  logic                                  Clock,
  input  logic                                  Reset,
  input  logic [ROWS-1:0]                       RowIn,
  output wire  [COLS-1:0]                       ColOut,
  output logic                                  KeyRdy,
  input  logic                                  KeyRd,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0]  KeyCode,
  output logic                                  KeyDown,
  output logic                                  MultiKey
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int KW = RW + CW;
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int ZW = $clog2(ROWS*COLS + 1);
  localparam logic [3:0] DB_N = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, PRESS_DB, WAIT_READ, RELEASE_DB} state_t;

  logic [ROWS-1:0]      sync1_q, sync2_q;
  logic [SW-1:0]        settle_q;
  logic [CW-1:0]        col_q;
  logic [ROWS*COLS-1:0] snap_q;
  logic                 eval_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      settle_q <= '0;
      col_q    <= '0;
      snap_q   <= '1;
      eval_q   <= 1'b0;
    end else begin
      sync1_q <= RowIn;
      sync2_q <= sync1_q;
      eval_q  <= 1'b0;
      if (settle_q == SW'(SETTLE_CYCLES-1)) begin
        settle_q <= '0;
        snap_q[col_q*ROWS +: ROWS] <= sync2_q;
        if (col_q == CW'(COLS-1)) begin
          col_q  <= '0;
          eval_q <= 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end else begin
        settle_q <= settle_q + 1'b1;
      end
    end
  end

  // Open-drain columns: only the active one pulls low, and none while in reset.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign ColOut[c] = (!Reset && col_q == CW'(c)) ? 1'b0 : 1'bz;
  end

  logic [ZW-1:0] zcnt;
  logic [KW-1:0] hit_code;
  always_comb begin
    zcnt     = '0;
    hit_code = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!snap_q[c*ROWS + r]) begin
          zcnt     = zcnt + 1'b1;
          hit_code = {RW'(r), CW'(c)};
        end
      end
    end
  end

  logic single_w, empty_w;
  assign single_w = eval_q && (zcnt == ZW'(1));
  assign empty_w  = eval_q && (zcnt != ZW'(1));

  state_t        state_q, state_d;
  logic [KW-1:0] cand_q, cand_d, code_q, code_d;
  logic [3:0]    stable_q, stable_d, rel_q, rel_d;
  logic          rdy_q, rdy_d, down_q, down_d, multi_q, multi_d;
`ifdef KEYPAD_REPEAT_EN
  localparam int PW = $clog2(REPEAT_FRAMES + 1);
  logic [PW-1:0] rpt_q, rpt_d;
`else
  localparam int unused_repeat_frames = REPEAT_FRAMES;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      code_q   <= '0;
      stable_q <= '0;
      rel_q    <= '0;
      rdy_q    <= 1'b0;
      down_q   <= 1'b0;
      multi_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      code_q   <= code_d;
      stable_q <= stable_d;
      rel_q    <= rel_d;
      rdy_q    <= rdy_d;
      down_q   <= down_d;
      multi_q  <= multi_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q    <= rpt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    code_d   = code_q;
    stable_d = stable_q;
    rel_d    = rel_q;
    rdy_d    = rdy_q;
    down_d   = down_q;
    multi_d  = eval_q && (zcnt > ZW'(1));
`ifdef KEYPAD_REPEAT_EN
    rpt_d    = rpt_q;
`endif
    case (state_q)
      IDLE: begin
        if (single_w) begin
          cand_d   = hit_code;
          stable_d = 4'd1;
          rel_d    = '0;
          if (DEBOUNCE_FRAMES == 1) begin
            code_d  = hit_code;
            rdy_d   = 1'b1;
            down_d  = 1'b1;
            state_d = WAIT_READ;
          end else begin
            state_d = PRESS_DB;
          end
        end
      end
      PRESS_DB: begin
        if (single_w && hit_code == cand_q) begin
          if (stable_q != 4'hF) stable_d = stable_q + 4'd1;
          if (stable_d >= DB_N) begin
            code_d  = cand_q;
            rdy_d   = 1'b1;
            down_d  = 1'b1;
            rel_d   = '0;
            state_d = WAIT_READ;
          end
        end else if (single_w) begin
          cand_d   = hit_code;
          stable_d = 4'd1;
        end else if (empty_w) begin
          state_d = IDLE;
        end
      end
      WAIT_READ: begin
        // Release is tracked here too so KeyDown can fall before the read.
        if (empty_w) begin
          if (rel_q != DB_N) rel_d = rel_q + 4'd1;
          if (rel_d == DB_N) down_d = 1'b0;
        end else if (single_w) begin
          rel_d = '0;
        end
        if (KeyRd && rdy_q) begin
          rdy_d   = 1'b0;
          state_d = down_d ? RELEASE_DB : IDLE;
`ifdef KEYPAD_REPEAT_EN
          rpt_d   = '0;
`endif
        end
      end
      RELEASE_DB: begin
        if (empty_w) begin
          if (rel_q != DB_N) rel_d = rel_q + 4'd1;
          if (rel_d == DB_N) begin
            down_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (single_w) begin
          rel_d = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        if (single_w && hit_code == code_q) begin
          if (rpt_q == PW'(REPEAT_FRAMES-1)) begin
            rpt_d   = '0;
            rdy_d   = 1'b1;
            state_d = WAIT_READ;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end else if (eval_q) begin
          rpt_d = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign KeyRdy   = rdy_q;
  assign KeyCode  = code_q;
  assign KeyDown  = down_q;
  assign MultiKey = multi_q;

endmodule
